// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU float-scale path: element and exponent widths,
// scale-mode encodings and the feeder state type.
package valu_pkg;

    localparam int unsigned ELEM_W = 20;
    localparam int unsigned EXP_W  = 8;

    localparam logic [1:0] SIG_ZERO = 2'b00;
    localparam logic [1:0] SIG_Q    = 2'b01;
    localparam logic [1:0] SIG_E    = 2'b11;
    localparam logic [1:0] SIG_RSVD = 2'b10;

    typedef enum logic {
        StIdle  = 1'b0,
        StIssue = 1'b1
    } feed_state_e;

endpackage

// File: rtl/scale_feeder.sv
// Buffers one packed vector descriptor and issues its elements one per cycle to the scale
// stage, with valid/last copies delayed one cycle to line up with the scale stage result.
module scale_feeder
    import valu_pkg::*;
#(
    parameter int unsigned VLEN = 8,
    parameter int unsigned LW   = $clog2(VLEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vec_valid,
    output logic                     vec_ready,
    input  logic [VLEN*ELEM_W-1:0]   vec_data,
    input  logic [EXP_W-1:0]         vec_exp,
    input  logic [1:0]               vec_sig,
    input  logic [LW-1:0]            vec_len,
    output logic [ELEM_W-1:0]        elem_in,
    output logic [1:0]               elem_sig,
    output logic [EXP_W-1:0]         elem_exp,
    output logic                     elem_valid,
    output logic                     elem_last,
    input  logic                     elem_ready,
    output logic                     res_valid,
    output logic                     res_last,
    output logic                     sig_err,
    output logic                     busy
);

    localparam int unsigned IW = $clog2(VLEN);

    feed_state_e               r_state;
    logic [IW-1:0]             r_idx;
    logic [VLEN*ELEM_W-1:0]    r_buf;
    logic [LW-1:0]             r_len;
    logic [EXP_W-1:0]          r_exp;
    logic [1:0]                r_sig;
    logic [ELEM_W-1:0]         r_elem_in;
    logic [1:0]                r_elem_sig;
    logic [EXP_W-1:0]          r_elem_exp;
    logic                      r_elem_last;
    logic                      r_res_valid;
    logic                      r_res_last;
    logic                      r_sig_err;

    logic                      w_busy;
    logic                      w_issue;
    logic                      w_vec_ready;
    logic                      w_cap;
    logic [LW-1:0]             w_len;
    logic [1:0]                w_sig;
    logic [IW-1:0]             w_idx_inc;
    logic [ELEM_W-1:0]         w_nxt_elem;
    logic                      w_nxt_last;

    assign w_busy      = (r_state == StIssue);
    assign w_issue     = w_busy & elem_ready;
    // Accept the next descriptor on the same edge the current vector's last element leaves.
    assign w_vec_ready = !w_busy | (r_elem_last & elem_ready);
    assign w_cap       = vec_valid & w_vec_ready;
    assign w_len       = (vec_len > LW'(VLEN)) ? LW'(VLEN) : vec_len;
    assign w_sig       = (vec_sig == SIG_RSVD) ? SIG_ZERO : vec_sig;
    assign w_idx_inc   = r_idx + IW'(1);
    assign w_nxt_elem  = r_buf[int'(w_idx_inc)*ELEM_W +: ELEM_W];
    assign w_nxt_last  = (LW'(w_idx_inc) == (r_len - LW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_buf       <= '0;
            r_len       <= '0;
            r_exp       <= '0;
            r_sig       <= '0;
            r_elem_in   <= '0;
            r_elem_sig  <= '0;
            r_elem_exp  <= '0;
            r_elem_last <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_sig_err   <= 1'b0;
        end else begin
            r_res_valid <= w_issue;
            r_res_last  <= w_issue & r_elem_last;
            r_sig_err   <= w_cap & (vec_sig == SIG_RSVD);

            if (w_cap) begin
                r_buf <= vec_data;
                r_exp <= vec_exp;
                r_sig <= w_sig;
                r_len <= w_len;
                r_idx <= '0;
                if (w_len != '0) begin
                    r_state     <= StIssue;
                    r_elem_in   <= vec_data[ELEM_W-1:0];
                    r_elem_sig  <= w_sig;
                    r_elem_exp  <= vec_exp;
                    r_elem_last <= (w_len == LW'(1));
                end else begin
                    r_state     <= StIdle;
                    r_elem_in   <= '0;
                    r_elem_sig  <= '0;
                    r_elem_exp  <= '0;
                    r_elem_last <= 1'b0;
                end
            end else if (w_issue) begin
                if (!r_elem_last) begin
                    r_idx       <= w_idx_inc;
                    r_elem_in   <= w_nxt_elem;
                    r_elem_sig  <= r_sig;
                    r_elem_exp  <= r_exp;
                    r_elem_last <= w_nxt_last;
                end else begin
                    // Zeroed operands make the scale stage produce +0 while idle.
                    r_state     <= StIdle;
                    r_elem_in   <= '0;
                    r_elem_sig  <= '0;
                    r_elem_exp  <= '0;
                    r_elem_last <= 1'b0;
                end
            end
        end
    end

    assign vec_ready  = w_vec_ready;
    assign elem_in    = r_elem_in;
    assign elem_sig   = r_elem_sig;
    assign elem_exp   = r_elem_exp;
    assign elem_valid = w_busy;
    assign elem_last  = r_elem_last;
    assign res_valid  = r_res_valid;
    assign res_last   = r_res_last;
    assign sig_err    = r_sig_err;
    assign busy       = w_busy;

endmodule

// File: tb/tb_scale_feeder.sv
// Directed table-driven bench for scale_feeder, plus a hand-written mid-vector reset sequence.
module tb_scale_feeder;

    localparam int VLEN = 8;
    localparam int LW   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              vec_valid;
    logic              vec_ready;
    logic [VLEN*20-1:0] vec_data;
    logic [7:0]        vec_exp;
    logic [1:0]        vec_sig;
    logic [LW-1:0]     vec_len;
    logic [19:0]       elem_in;
    logic [1:0]        elem_sig;
    logic [7:0]        elem_exp;
    logic              elem_valid;
    logic              elem_last;
    logic              elem_ready;
    logic              res_valid;
    logic              res_last;
    logic              sig_err;
    logic              busy;

    always #5 clk = ~clk;

    scale_feeder #(.VLEN(VLEN), .LW(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_data   (vec_data),
        .vec_exp    (vec_exp),
        .vec_sig    (vec_sig),
        .vec_len    (vec_len),
        .elem_in    (elem_in),
        .elem_sig   (elem_sig),
        .elem_exp   (elem_exp),
        .elem_valid (elem_valid),
        .elem_last  (elem_last),
        .elem_ready (elem_ready),
        .res_valid  (res_valid),
        .res_last   (res_last),
        .sig_err    (sig_err),
        .busy       (busy)
    );

    typedef struct {
        bit        vv;
        int        len;
        bit [1:0]  sig;
        int        vid;
        bit        er;
        bit        ev;
        bit [19:0] ein;
        bit        el;
        bit [1:0]  esig;
        bit        rv;
        bit        rl;
        bit        vr;
        bit        se;
    } row_t;

    row_t rows[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic [19:0] elem(input int vid, input int i);
        if (vid == 0) begin
            case (i)
                0:       return 20'h00001;
                1:       return 20'h80002;
                2:       return 20'h7FFFF;
                3:       return 20'h40000;
                default: return 20'h00000;
            endcase
        end
        return 20'(vid * 256 + i + 1);
    endfunction

    function automatic logic [VLEN*20-1:0] vdata(input int vid);
        logic [VLEN*20-1:0] v;
        v = '0;
        for (int i = 0; i < VLEN; i++) v[i*20 +: 20] = elem(vid, i);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit vv, input int len, input bit [1:0] sig, input int vid,
                       input bit er, input bit ev, input bit [19:0] ein, input bit el,
                       input bit [1:0] esig, input bit rv, input bit rl, input bit vr,
                       input bit se);
        row_t r;
        r.vv = vv; r.len = len; r.sig = sig; r.vid = vid; r.er = er;
        r.ev = ev; r.ein = ein; r.el = el; r.esig = esig;
        r.rv = rv; r.rl = rl; r.vr = vr; r.se = se;
        rows.push_back(r);
    endtask

    task automatic idle_row(input bit rv, input bit rl);
        add(0, 0, 2'b00, 0, 1, 0, 20'h0, 0, 2'b00, rv, rl, 1, 0);
    endtask

    initial begin
        // Single vector, len=4
        add(1, 4, 2'b01, 0, 1, 0, 20'h0, 0, 2'b00, 0, 0, 1, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h00001, 0, 2'b01, 0, 0, 0, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h80002, 0, 2'b01, 1, 0, 0, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h7FFFF, 0, 2'b01, 1, 0, 0, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h40000, 1, 2'b01, 1, 0, 1, 0);
        idle_row(1, 1);
        idle_row(0, 0);
        // Back-to-back A(len=2) then B(len=3)
        add(1, 2, 2'b11, 1, 1, 0, 20'h0, 0, 2'b00, 0, 0, 1, 0);
        add(1, 3, 2'b11, 2, 1, 1, 20'h00101, 0, 2'b11, 0, 0, 0, 0);
        add(1, 3, 2'b11, 2, 1, 1, 20'h00102, 1, 2'b11, 1, 0, 1, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h00201, 0, 2'b11, 1, 1, 0, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h00202, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h00203, 1, 2'b11, 1, 0, 1, 0);
        idle_row(1, 1);
        idle_row(0, 0);
        // Backpressure, ready pattern 1,0,0,1,1
        add(1, 3, 2'b01, 3, 1, 0, 20'h0, 0, 2'b00, 0, 0, 1, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h00301, 0, 2'b01, 0, 0, 0, 0);
        add(0, 0, 2'b00, 0, 0, 1, 20'h00302, 0, 2'b01, 1, 0, 0, 0);
        add(0, 0, 2'b00, 0, 0, 1, 20'h00302, 0, 2'b01, 0, 0, 0, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h00302, 0, 2'b01, 0, 0, 0, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h00303, 1, 2'b01, 1, 0, 1, 0);
        idle_row(1, 1);
        idle_row(0, 0);
        // Reserved mode
        add(1, 1, 2'b10, 4, 1, 0, 20'h0, 0, 2'b00, 0, 0, 1, 0);
        add(0, 0, 2'b00, 0, 1, 1, 20'h00401, 1, 2'b00, 0, 0, 1, 1);
        idle_row(1, 1);
        idle_row(0, 0);
        // Zero length
        add(1, 0, 2'b01, 5, 1, 0, 20'h0, 0, 2'b00, 0, 0, 1, 0);
        idle_row(0, 0);
        idle_row(0, 0);
        // Oversize length clamps to VLEN
        add(1, 12, 2'b01, 6, 1, 0, 20'h0, 0, 2'b00, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 2'b00, 0, 1, 1, 20'(6 * 256 + i + 1), (i == 7), 2'b01,
                (i > 0), 0, (i == 7), 0);
        idle_row(1, 1);
        idle_row(0, 0);

        rst_n      = 1'b0;
        vec_valid  = 1'b0;
        vec_data   = '0;
        vec_exp    = 8'h7F;
        vec_sig    = 2'b00;
        vec_len    = '0;
        elem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset elem_valid", elem_valid, 0);
        chk("reset elem_in", elem_in, 0);
        chk("reset elem_sig", elem_sig, 0);
        chk("reset elem_exp", elem_exp, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset sig_err", sig_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < rows.size(); r++) begin
            vec_valid  = rows[r].vv;
            vec_len    = LW'(rows[r].len);
            vec_sig    = rows[r].sig;
            vec_data   = vdata(rows[r].vid);
            elem_ready = rows[r].er;
            #1;
            chk($sformatf("row%0d elem_valid", r), elem_valid, rows[r].ev);
            chk($sformatf("row%0d elem_in", r), elem_in, rows[r].ein);
            chk($sformatf("row%0d elem_last", r), elem_last, rows[r].el);
            chk($sformatf("row%0d elem_sig", r), elem_sig, rows[r].esig);
            chk($sformatf("row%0d elem_exp", r), elem_exp, rows[r].ev ? 8'h7F : 8'h00);
            chk($sformatf("row%0d res_valid", r), res_valid, rows[r].rv);
            chk($sformatf("row%0d res_last", r), res_last, rows[r].rl);
            chk($sformatf("row%0d vec_ready", r), vec_ready, rows[r].vr);
            chk($sformatf("row%0d busy", r), busy, rows[r].ev);
            chk($sformatf("row%0d sig_err", r), sig_err, rows[r].se);
            @(posedge clk);
            #1;
        end

        // Reset mid-vector: len=5, reset after two issues
        vec_valid  = 1'b1;
        vec_len    = 4'd5;
        vec_sig    = 2'b11;
        vec_data   = vdata(7);
        elem_ready = 1'b1;
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst pre elem_in", elem_in, 20'h00703);
        chk("midrst pre res_valid", res_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst elem_valid", elem_valid, 0);
        chk("midrst res_valid", res_valid, 0);
        chk("midrst busy", busy, 0);
        chk("midrst elem_in", elem_in, 0);
        chk("midrst elem_sig", elem_sig, 0);
        chk("midrst elem_exp", elem_exp, 0);
        chk("midrst elem_last", elem_last, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midrst vec_ready", vec_ready, 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-rst%0d elem_valid", c), elem_valid, 0);
            chk($sformatf("post-rst%0d res_valid", c), res_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
